// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment display block.
//   - bcd_state_e : conversion FSM encoding (IDLE, SHIFT, DONE)
//   - AN_BLANK    : all-ones anode pattern (every digit off), sliced to width
//   - pow10(n)    : 10**n, used for the overflow threshold
package seg7_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_e;

  localparam logic [31:0] AN_BLANK = '1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/multi_digit_7seg_scan_if.sv
// Bus between the score/timer logic and the display block.
//   master : drives value/load/blank_lz/dp_in, reads seg/dp/an/busy/ovf
//   slave  : the display block itself
interface multi_digit_7seg_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
);
  logic [BIN_W-1:0]      value;
  logic                  load;
  logic                  blank_lz;
  logic [NUM_DIGITS-1:0] dp_in;
  logic [6:0]            seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] an;
  logic                  busy;
  logic                  ovf;

  modport master (output value, load, blank_lz, dp_in,
                  input  seg, dp, an, busy, ovf);
  modport slave  (input  value, load, blank_lz, dp_in,
                  output seg, dp, an, busy, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one bit per clock.
//   load_i/value_i : capture request (ignored while busy)
//   busy_o         : conversion in flight (state != IDLE)
//   done_o         : high for the single DONE cycle; result_o valid then
//   result_o       : BCD digits, or all nines on overflow
//   ovf_o          : last captured value did not fit in NUM_DIGITS digits
module bin2bcd_seq import seg7_pkg::*; #(
  parameter int BIN_W      = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_i,
  input  logic [BIN_W-1:0]            value_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        ovf_o,
  output logic [NUM_DIGITS-1:0][3:0]  result_o
);
  localparam int CNT_W = $clog2(BIN_W + 1);

  bcd_state_e                state_q;
  logic [BIN_W-1:0]          bin_q;
  logic [NUM_DIGITS-1:0][3:0] bcd_q, adj;
  logic [CNT_W-1:0]          cnt_q;
  logic                      ovf_pend_q, ovf_q, ready_q;
  logic [4*NUM_DIGITS+BIN_W-1:0] sh;

  // add-3 on every nibble >= 5, then shift the combined register
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd_q[i] >= 4'd5) adj[i] = bcd_q[i] + 4'd3;
    sh = {adj, bin_q} << 1;
  end

  // ready_q masks a load that coincides with the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        IDLE: if (load_i && ready_q) begin
          bin_q      <= value_i;
          bcd_q      <= '0;
          cnt_q      <= CNT_W'(BIN_W);
          ovf_pend_q <= (64'(value_i) >= pow10(NUM_DIGITS));
          state_q    <= SHIFT;
        end
        SHIFT: begin
          {bcd_q, bin_q} <= sh;
          cnt_q          <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= DONE;
        end
        DONE: begin
          ovf_q   <= ovf_pend_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign ovf_o    = ovf_q;
  assign result_o = ovf_pend_q ? {NUM_DIGITS{4'd9}} : bcd_q;
endmodule

// File: rtl/seven_seg_decoder.sv
// BCD digit to common-anode segment pattern.
//   digit_i : 4-bit digit (10..15 show nothing)
//   seg_o   : {g,f,e,d,c,b,a}, active-low
module seven_seg_decoder (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (digit_i)
      4'd0:    seg_o = 7'h40;
      4'd1:    seg_o = 7'h79;
      4'd2:    seg_o = 7'h24;
      4'd3:    seg_o = 7'h30;
      4'd4:    seg_o = 7'h19;
      4'd5:    seg_o = 7'h12;
      4'd6:    seg_o = 7'h02;
      4'd7:    seg_o = 7'h78;
      4'd8:    seg_o = 7'h00;
      4'd9:    seg_o = 7'h10;
      default: seg_o = 7'h7F;
    endcase
  end
endmodule

// File: rtl/multi_digit_7seg_scan.sv
// Binary value -> BCD -> time-multiplexed common-anode display.
//   clk_1k : scan and conversion clock, one digit per cycle
//   rst_n  : async active-low reset
//   io     : value/load/blank_lz/dp_in in; seg/dp/an/busy/ovf out
module multi_digit_7seg_scan import seg7_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                   clk_1k,
  input  logic                   rst_n,
  multi_digit_7seg_scan_if.slave io
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [IDX_W-1:0]           idx_q;
  logic [NUM_DIGITS-1:0][3:0] disp_q, result;
  logic                       done;
  logic [NUM_DIGITS-1:0]      blank, an_d;
  logic                       run;
  logic [3:0]                 nibble;

  bin2bcd_seq #(.BIN_W(BIN_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk      (clk_1k),
    .rst_n    (rst_n),
    .load_i   (io.load),
    .value_i  (io.value),
    .busy_o   (io.busy),
    .done_o   (done),
    .ovf_o    (io.ovf),
    .result_o (result)
  );

  // display register only moves on DONE, so partial results never show
  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      disp_q <= '0;
    end else begin
      idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      if (done) disp_q <= result;
    end
  end

  // walk down from the top digit; blank while the run of zeros is unbroken
  always_comb begin
    run   = 1'b1;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run      = run && (disp_q[i] == 4'd0);
      blank[i] = io.blank_lz && run && (i != 0);
    end
  end

  always_comb begin
    an_d = AN_BLANK[NUM_DIGITS-1:0];
    if (!blank[idx_q]) an_d[idx_q] = 1'b0;
  end

  assign nibble = disp_q[idx_q];
  assign io.an  = an_d;
  assign io.dp  = ~io.dp_in[idx_q];

  seven_seg_decoder u_dec (
    .digit_i (nibble),
    .seg_o   (io.seg)
  );
endmodule

// File: doc/multi_digit_7seg_scan.md
# multi_digit_7seg_scan

Parametrised successor to the two-digit score display. It accepts a plain binary value, converts it to BCD with a sequential double-dabble engine, and time-multiplexes NUM_DIGITS common-anode digits at one digit per clock. It adds optional leading-zero blanking, per-digit decimal points and overflow saturation. It sits between the game score/timer logic and the board's seven-segment pins.

## Interface
Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; must be ≥1.
- BIN_W, 14: width of the binary input; must be ≥4.

Ports:
- clk_1k  in  1: scan and conversion clock.
- rst_n  in  1: asynchronous, active-low reset.
- value  in  BIN_W: unsigned binary value to display.
- load  in  1: single-cycle request to capture `value` and convert it.
- blank_lz  in  1: level; 1 enables leading-zero blanking.
- dp_in  in  NUM_DIGITS: decimal-point request per digit, bit i = digit i.
- seg  out  7: segment pattern of the active digit, from seven_seg_decoder.
- dp  out  1: decimal point, active-low.
- an  out  NUM_DIGITS: digit enables, active-low, at most one bit low.
- busy  out  1: conversion in progress; `load` is ignored while high.
- ovf  out  1: last captured value was ≥ 10^NUM_DIGITS.

## Operation
- Conversion FSM has three states: IDLE, SHIFT and DONE.
- IDLE with `load`=1:
  - Capture `value` into the shift register.
  - Clear the BCD accumulator (4·NUM_DIGITS bits).
  - Set bit counter = BIN_W.
  - Latch ovf_pending = (value ≥ 10^NUM_DIGITS).
  - Go to SHIFT.
- SHIFT, each cycle:
  - Add 3 to every BCD nibble ≥5.
  - Shift {bcd, bin} left by 1.
  - Decrement the counter.
  - When the counter reaches 0, go to DONE.
- DONE:
  - Write the display register: BCD result, or all nibbles = 9 if ovf_pending.
  - ovf ← ovf_pending.
  - Go to IDLE.
- busy = (state ≠ IDLE).
- `load` in SHIFT or DONE is dropped; there is no queueing.
- Scan counter `idx` runs 0..NUM_DIGITS-1 and wraps to 0. It advances every cycle, independent of the FSM.
- Outputs are combinational from `idx`, the display register, blank_lz and dp_in:
  - an = all ones with bit idx cleared, unless digit idx is blanked, in which case an = all ones.
  - seg = decoder(nibble[idx]).
  - dp = ~dp_in[idx]; dp_in is used live.
- Blanking: digit i>0 is blanked when blank_lz=1 and nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked, so value 0 shows "0".
- A blanked digit whose dp_in bit is set is still blanked; an stays all ones.
- The display register changes only in DONE. The displayed digits never show partial conversion results.

## Timing
- Reset values:
  - state = IDLE, busy = 0, ovf = 0, idx = 0.
  - display register = 0.
  - Resulting outputs: an = {1…1,0}, seg = glyph "0", dp = ~dp_in[0].
- Load latency, with `load` sampled at edge k:
  - busy is high after edge k.
  - SHIFT occupies edges k+1..k+BIN_W.
  - DONE updates the display register and ovf at edge k+BIN_W+1.
  - busy is low after edge k+BIN_W+1, i.e. busy is high for BIN_W+1 cycles.
  - The earliest accepted reload is at edge k+BIN_W+1+1.
- Scan period is NUM_DIGITS cycles. Each digit is enabled for exactly one cycle per period (4 ms refresh at 1 kHz, NUM_DIGITS=4).
- Asserting rst_n mid-conversion aborts the conversion. The display register returns to 0 and ovf to 0. No partial result is ever written.
- `load` arriving in the same cycle as reset release is ignored.

## Structure
- Shared package seg7_pkg holds:
  - the FSM state encoding (IDLE, SHIFT, DONE);
  - the localparam-style constant function pow10(n) used for the overflow threshold;
  - the blank an pattern constant.
- Sub-module bin2bcd_seq (parameters BIN_W, NUM_DIGITS) contains the FSM, the shift/add-3 datapath, the counter, busy and ovf.
- The top level contains:
  - the scan counter;
  - the display register;
  - the blanking logic;
  - one seven_seg_decoder instance, fed by the muxed nibble.

## Test plan
All scenarios use NUM_DIGITS=4, BIN_W=14.
1. Reset with dp_in=0 → an=1110, seg=glyph "0", dp=1, busy=0, ovf=0. Over the next 4 cycles an steps 1101, 1011, 0111, then back to 1110.
2. load value=1234, blank_lz=0 → busy high for exactly 15 cycles. Afterwards the an=1110/1101/1011/0111 slots show glyphs 4/3/2/1. ovf=0.
3. load value=7:
   - blank_lz=1 → slot 0 shows "7"; slots 1–3 drive an=1111.
   - blank_lz=0 → display "0007".
   - value=0 with blank_lz=1 → only digit 0 lit, glyph "0".
4. load value=12000 → ovf=1, all digits show "9". Then load 9999 → ovf=0, all digits "9".
5. Interference during conversion:
   - load 1234, then load 5555 two cycles later → 5555 is ignored and the display shows 1234.
   - load 4321, then drop rst_n at cycle 5 → busy=0 and the display shows 0000 after release.
6. dp_in=4'b0100 with value 1234 → dp=0 only while an=1011, dp=1 in all other slots. Changing dp_in takes effect on the next scan slot with no load.
